mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Consumes the registered execute→memory bundle (`ex_to_mem_s`) and performs word loads/stores on the data-memory request/ack port.
- Registers the result for writeback and drives the two bypass values that execute forwards from (`bp_mem`, `bp_wb`).
- Owns the multi-cycle memory handshake. Raises `stall` to freeze upstream stages while a data-memory access is outstanding.

Parameters:
- `ALIGN_MASK`, default `2'b11`: address low bits that must be zero for a legal word access. Used only when `MEM_MISALIGN_TRAP_EN` is defined.
- `MAX_WAIT`, default 16: ack timeout in cycles. On expiry, `timeout` pulses and the access is abandoned.

Ports:
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `ex_to_mem` input `ex_to_mem_s`: `alu_result`, `write_data`, `mem_write`, `reg_write`, `rd`, `mem_read`.
- `dmem_req` output 1: data-memory request valid.
- `dmem_we` output 1: 1 = store, 0 = load.
- `dmem_addr` output 32: byte address.
- `dmem_wdata` output 32: store data.
- `dmem_rdata` input 32: load data, valid when `dmem_ack` = 1.
- `dmem_ack` input 1: access complete this cycle.
- `stall` output 1: hold fetch/decode/execute registers this cycle.
- `bp_mem` output 32: forwarding value from MEM, equal to `ex_to_mem.alu_result` (combinational).
- `bp_wb` output 32: forwarding value from WB, equal to `wb_data`.
- `wb_data` output 32: registered writeback value.
- `wb_rd` output 5: registered destination register.
- `wb_reg_write` output 1: registered write enable.
- `timeout` output 1: one-cycle pulse on ack timeout.
- `misalign` output 1: one-cycle pulse, present only with `MEM_MISALIGN_TRAP_EN`.

Behaviour:
- **Reset:** one cycle of `rst` = 1 at posedge clears state to IDLE and clears the wait counter. All of `wb_data`, `wb_rd`, `wb_reg_write`, `timeout`, `misalign` clear to 0. `dmem_req` and `stall` are 0 from that cycle on. Reset in WAIT abandons the access with no writeback.
- **Access detect:** `acc` = `ex_to_mem.mem_read` | `ex_to_mem.mem_write`. If both are set, the store wins (`dmem_we` = 1) and `wb_data` = `alu_result`.
- **IDLE, `acc` = 0:**
  - `dmem_req` = 0 and `stall` = 0.
  - Next cycle: `wb_data` = `alu_result`, `wb_rd` = `rd`, `wb_reg_write` = `reg_write` & (`rd` != 0).
- **IDLE, `acc` = 1:**
  - Same cycle: `dmem_req` = 1, `dmem_addr` = `alu_result`, `dmem_we` = `mem_write`, `dmem_wdata` = `write_data`.
  - If `dmem_ack` = 1 this cycle, the access completes with zero stall. Next-cycle `wb_data` = load ? `dmem_rdata` : `alu_result`.
  - If `dmem_ack` = 0: `stall` = 1 combinationally this cycle. The request fields plus `rd`, `reg_write`, `mem_read` are latched into a capture register, and the FSM enters WAIT.
- **WAIT:**
  - `dmem_req` = 1 with the captured fields, held stable regardless of the `ex_to_mem` input.
  - `stall` = 1 until the ack cycle. `stall` is 0 in the ack cycle itself.
  - Each posedge without ack, `wb_reg_write` <= 0 (bubble).
  - On `dmem_ack`: writeback registers load from the captured fields (data = `dmem_rdata` for a load), and the FSM returns to IDLE.
- **Ack timing:** latency is 1 + number of WAIT cycles. Back-to-back accesses are allowed: an access in IDLE in the cycle after WAIT exits is accepted normally.
- **Timeout:** the wait counter increments each WAIT cycle. When it reaches `MAX_WAIT` without ack:
  - `timeout` pulses for 1 cycle, `dmem_req` drops, and the FSM returns to IDLE.
  - Writeback is a bubble (`wb_reg_write` = 0).
  - The counter clears on every IDLE entry.
- **Ack outside a request:** `dmem_ack` while `dmem_req` = 0 is ignored.
- **Load-use hazard:** `bp_mem` carries `alu_result`, never load data. Load-use hazards remain the hazard unit's responsibility.

Optional Feature:
- **Macro `MEM_MISALIGN_TRAP_EN` defined:**
  - When `acc` = 1 in IDLE and (`alu_result` & `ALIGN_MASK`) != 0: `dmem_req` stays 0 and `stall` stays 0.
  - `misalign` pulses 1 on the next cycle, and writeback is a bubble.
- **Not defined:** no alignment check. The address is issued unmodified, and the `misalign` port is tied to 0.

Test Plan:
1. **ALU pass-through:** `reg_write` = 1, `rd` = 5, `alu_result` = 0x1234, no access → next cycle `wb_rd` = 5, `wb_data` = 0x1234, `wb_reg_write` = 1, `stall` = 0.
2. **Zero-wait load:** `mem_read`, addr 0x100, `dmem_ack` same cycle, `rdata` 0xDEADBEEF, `rd` = 7 → `dmem_req` = 1 for 1 cycle, `stall` never 1, next cycle `wb_data` = 0xDEADBEEF.
3. **3-cycle-ack store:** `mem_write`, addr 0x200, data 0xA5A5A5A5, and the `ex_to_mem` input changes after the first cycle → `dmem_addr`/`dmem_wdata` remain 0x200/0xA5A5A5A5, `stall` = 1 for exactly 2 cycles, `wb_reg_write` = 0.
4. **Write to x0:** `rd` = 0, `reg_write` = 1, `alu_result` = 0x55 → `wb_reg_write` = 0.
5. **Timeout:** `MAX_WAIT` = 4 and ack never arrives → `timeout` pulses at WAIT cycle 4, `dmem_req` then 0, `stall` = 0, state IDLE.
6. **Reset in WAIT, then misaligned access:** `rst` = 1 during WAIT → next cycle `dmem_req` = 0, `stall` = 0, all wb outputs 0. Then with `MEM_MISALIGN_TRAP_EN`, a load at 0x102 → no `dmem_req`, `misalign` = 1 for one cycle, `wb_reg_write` = 0.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I memory stage: word load/store over a req/ack port, writeback registers and bypass values.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned accesses with a one-cycle misalign pulse.
package mem_stage_pkg;
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  rd;
        logic        mem_read;
    } ex_to_mem_s;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [1:0]  ALIGN_MASK = 2'b11,
    parameter int unsigned MAX_WAIT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_to_mem_s  ex_to_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] bp_mem,
    output logic [31:0] bp_wb,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        timeout,
    output logic        misalign
);
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ex_to_mem_s      cap_q, cap_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic            timeout_q, timeout_d;
    logic            misalign_q, misalign_d;
    logic            acc;
    logic            mis;

    assign acc = ex_to_mem.mem_read | ex_to_mem.mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = |(ex_to_mem.alu_result[1:0] & ALIGN_MASK);
`else
    logic unused_align;
    assign unused_align = ^ALIGN_MASK;
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cap_d          = cap_q;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        timeout_d      = 1'b0;
        misalign_d     = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = ex_to_mem.mem_write;
        dmem_addr      = ex_to_mem.alu_result;
        dmem_wdata     = ex_to_mem.write_data;
        stall          = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!acc) begin
                    wb_data_d      = ex_to_mem.alu_result;
                    wb_rd_d        = ex_to_mem.rd;
                    wb_reg_write_d = ex_to_mem.reg_write & (ex_to_mem.rd != 5'd0);
                end else if (mis) begin
                    misalign_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        // Store wins when both read and write are set.
                        wb_data_d      = (ex_to_mem.mem_read & ~ex_to_mem.mem_write) ?
                                         dmem_rdata : ex_to_mem.alu_result;
                        wb_rd_d        = ex_to_mem.rd;
                        wb_reg_write_d = ex_to_mem.reg_write & (ex_to_mem.rd != 5'd0);
                    end else begin
                        stall          = 1'b1;
                        cap_d          = ex_to_mem;
                        wb_reg_write_d = 1'b0;
                        state_d        = StWait;
                    end
                end
            end
            StWait: begin
                dmem_req   = 1'b1;
                dmem_we    = cap_q.mem_write;
                dmem_addr  = cap_q.alu_result;
                dmem_wdata = cap_q.write_data;
                if (dmem_ack) begin
                    wb_data_d      = (cap_q.mem_read & ~cap_q.mem_write) ?
                                     dmem_rdata : cap_q.alu_result;
                    wb_rd_d        = cap_q.rd;
                    wb_reg_write_d = cap_q.reg_write & (cap_q.rd != 5'd0);
                    cnt_d          = '0;
                    state_d        = StIdle;
                end else begin
                    stall          = 1'b1;
                    wb_reg_write_d = 1'b0;
                    if (cnt_q == CntW'(MAX_WAIT - 1)) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            cap_q          <= '0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            timeout_q      <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cap_q          <= cap_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            timeout_q      <= timeout_d;
            misalign_q     <= misalign_d;
        end
    end

    assign bp_mem       = ex_to_mem.alu_result;
    assign bp_wb        = wb_data_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign timeout      = timeout_q;
    assign misalign     = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, hand-written multi-cycle sequences, and a randomized run
// against a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned TbMaxWait = 4;

    logic        clk = 1'b0;
    logic        rst;
    ex_to_mem_s  ex_to_mem;
    logic        dmem_req, dmem_we, dmem_ack, stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, bp_mem, bp_wb, wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, timeout, misalign;

    int checks   = 0;
    int failures = 0;

    mem_stage #(
        .ALIGN_MASK (2'b11),
        .MAX_WAIT   (TbMaxWait)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_to_mem    (ex_to_mem),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall        (stall),
        .bp_mem       (bp_mem),
        .bp_wb        (bp_wb),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .timeout      (timeout),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_to_mem_s mk(input logic [31:0] alu, input logic [31:0] wd,
                                      input logic mr, input logic mw, input logic rw,
                                      input logic [4:0] rd);
        ex_to_mem_s e;
        e.alu_result = alu;
        e.write_data = wd;
        e.mem_read   = mr;
        e.mem_write  = mw;
        e.reg_write  = rw;
        e.rd         = rd;
        return e;
    endfunction

    function automatic bit tb_misaligned(input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic        mr, mw, rw;
        logic [4:0]  rd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_wb_data;
        logic [4:0]  e_wb_rd;
        logic        e_wb_we;
    } vec_t;

    vec_t vecs[6];

    // Reference model state: one outstanding transaction and the expected writeback registers.
    bit          m_busy;
    ex_to_mem_s  m_tx;
    int          m_waited;
    logic [31:0] e_wb_data;
    logic [4:0]  e_wb_rd;
    logic        e_wb_we, e_timeout, e_misalign;

    task automatic model_retire(input ex_to_mem_s t, input logic [31:0] rdata);
        e_wb_data = (t.mem_read && !t.mem_write) ? rdata : t.alu_result;
        e_wb_rd   = t.rd;
        e_wb_we   = t.reg_write && (t.rd != 0);
    endtask

    initial begin
        int          stalls;
        int          waited;
        bit          seen;
        ex_to_mem_s  rx;
        logic        r_ack;
        logic [31:0] r_rdata;
        int          kind;

        rst        = 1'b1;
        ex_to_mem  = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;

        vecs[0] = '{32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h1234, 5'd5, 1'b1};
        vecs[1] = '{32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 32'hDEADBEEF,
                    1'b1, 1'b0, 32'hDEADBEEF, 5'd7, 1'b1};
        vecs[2] = '{32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h55, 5'd0, 1'b0};
        vecs[3] = '{32'h300, 32'h11, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 32'hFFFF0000,
                    1'b1, 1'b1, 32'h300, 5'd3, 1'b0};
        vecs[4] = '{32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 32'hBAD,
                    1'b0, 1'b0, 32'h77, 5'd9, 1'b1};
        vecs[5] = '{32'hCAFE, 32'h0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'hCAFE, 5'd12, 1'b0};

        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
        chk("rst_wb_we", {31'b0, wb_reg_write}, 32'h0);
        chk("rst_timeout", {31'b0, timeout}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);

        // Single-cycle vectors, all starting and ending in IDLE.
        for (int i = 0; i < 6; i++) begin
            ex_to_mem  = mk(vecs[i].alu, vecs[i].wd, vecs[i].mr, vecs[i].mw, vecs[i].rw,
                            vecs[i].rd);
            dmem_ack   = vecs[i].ack;
            dmem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, 32'h0);
            chk($sformatf("vec%0d_bp_mem", i), bp_mem, vecs[i].alu);
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].e_we});
                chk($sformatf("vec%0d_addr", i), dmem_addr, vecs[i].alu);
            end
            cycle();
            chk($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].e_wb_data);
            chk($sformatf("vec%0d_wb_rd", i), {27'b0, wb_rd}, {27'b0, vecs[i].e_wb_rd});
            chk($sformatf("vec%0d_wb_we", i), {31'b0, wb_reg_write}, {31'b0, vecs[i].e_wb_we});
            chk($sformatf("vec%0d_bp_wb", i), bp_wb, vecs[i].e_wb_data);
        end

        // Store acked on the third request cycle; input changes while waiting.
        stalls     = 0;
        ex_to_mem  = mk(32'h200, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 5'd0);
        dmem_ack   = 1'b0;
        @(negedge clk);
        chk("st3_req0", {31'b0, dmem_req}, 32'h1);
        chk("st3_we0", {31'b0, dmem_we}, 32'h1);
        if (stall) stalls++;
        cycle();
        ex_to_mem = mk(32'hFFFF0000, 32'h12345678, 1'b1, 1'b0, 1'b1, 5'd4);
        for (int c = 0; c < 2; c++) begin
            dmem_ack   = (c == 1);
            dmem_rdata = 32'h99;
            @(negedge clk);
            chk($sformatf("st3_addr%0d", c), dmem_addr, 32'h200);
            chk($sformatf("st3_wdata%0d", c), dmem_wdata, 32'hA5A5A5A5);
            chk($sformatf("st3_req%0d", c + 1), {31'b0, dmem_req}, 32'h1);
            chk($sformatf("st3_wb_we%0d", c), {31'b0, wb_reg_write}, 32'h0);
            if (stall) stalls++;
            cycle();
        end
        chk("st3_stall_cycles", stalls, 2);
        chk("st3_wb_we_done", {31'b0, wb_reg_write}, 32'h0);
        chk("st3_wb_data", wb_data, 32'h200);
        // Back-to-back zero-wait load right after the WAIT exit.
        ex_to_mem  = mk(32'h104, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("b2b_req", {31'b0, dmem_req}, 32'h1);
        chk("b2b_stall", {31'b0, stall}, 32'h0);
        cycle();
        chk("b2b_wb_data", wb_data, 32'h0BADF00D);
        chk("b2b_wb_rd", {27'b0, wb_rd}, 32'd6);

        // Timeout: ack never arrives.
        ex_to_mem = mk(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8);
        dmem_ack  = 1'b0;
        @(negedge clk);
        chk("to_stall0", {31'b0, stall}, 32'h1);
        cycle();
        ex_to_mem = '0;
        waited    = 1;
        seen      = 1'b0;
        while (!seen && waited < 12) begin
            if (timeout) begin
                seen = 1'b1;
            end else begin
                chk($sformatf("to_req_w%0d", waited), {31'b0, dmem_req}, 32'h1);
                chk($sformatf("to_stall_w%0d", waited), {31'b0, stall}, 32'h1);
                cycle();
                waited++;
            end
        end
        chk("to_latency", waited, 1 + TbMaxWait);
        chk("to_req_after", {31'b0, dmem_req}, 32'h0);
        chk("to_stall_after", {31'b0, stall}, 32'h0);
        chk("to_wb_we", {31'b0, wb_reg_write}, 32'h0);
        cycle();
        chk("to_pulse_end", {31'b0, timeout}, 32'h0);

        // Reset while waiting.
        ex_to_mem = mk(32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
        cycle();
        ex_to_mem = '0;
        rst       = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rw_req", {31'b0, dmem_req}, 32'h0);
        chk("rw_stall", {31'b0, stall}, 32'h0);
        chk("rw_wb_data", wb_data, 32'h0);
        chk("rw_wb_rd", {27'b0, wb_rd}, 32'h0);
        chk("rw_wb_we", {31'b0, wb_reg_write}, 32'h0);

        // Misaligned load (ack offered; must be ignored when trapping).
        ex_to_mem  = mk(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1357;
        @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", {31'b0, dmem_req}, 32'h0);
        chk("mis_stall", {31'b0, stall}, 32'h0);
        cycle();
        ex_to_mem = '0;
        dmem_ack  = 1'b0;
        chk("mis_pulse", {31'b0, misalign}, 32'h1);
        chk("mis_wb_we", {31'b0, wb_reg_write}, 32'h0);
`else
        chk("mis_req", {31'b0, dmem_req}, 32'h1);
        chk("mis_addr", dmem_addr, 32'h102);
        cycle();
        ex_to_mem = '0;
        dmem_ack  = 1'b0;
        chk("mis_pulse", {31'b0, misalign}, 32'h0);
        chk("mis_wb_data", wb_data, 32'h1357);
`endif
        cycle();
        chk("mis_pulse_end", {31'b0, misalign}, 32'h0);

        // Randomized run against the reference model.
        rst = 1'b1;
        cycle();
        rst        = 1'b0;
        m_busy     = 1'b0;
        m_waited   = 0;
        e_wb_data  = '0;
        e_wb_rd    = '0;
        e_wb_we    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            kind          = int'($urandom_range(0, 7));
            rx.alu_result = $urandom();
            if ($urandom_range(0, 7) != 0) rx.alu_result[1:0] = 2'b00;
            rx.write_data = $urandom();
            rx.mem_read   = (kind >= 3 && kind <= 5) || kind == 7;
            rx.mem_write  = (kind >= 6);
            rx.reg_write  = 1'($urandom_range(0, 1));
            rx.rd         = 5'($urandom_range(0, 31));
            r_ack         = ($urandom_range(0, 9) < 4);
            r_rdata       = $urandom();
            ex_to_mem     = rx;
            dmem_ack      = r_ack;
            dmem_rdata    = r_rdata;
            @(negedge clk);
            chk("rnd_bp_mem", bp_mem, rx.alu_result);
            if (m_busy) begin
                chk("rnd_req", {31'b0, dmem_req}, 32'h1);
                chk("rnd_stall", {31'b0, stall}, {31'b0, !r_ack});
                chk("rnd_addr", dmem_addr, m_tx.alu_result);
                chk("rnd_wdata", dmem_wdata, m_tx.write_data);
                chk("rnd_we", {31'b0, dmem_we}, {31'b0, m_tx.mem_write});
            end else if ((rx.mem_read || rx.mem_write) && !tb_misaligned(rx.alu_result)) begin
                chk("rnd_req", {31'b0, dmem_req}, 32'h1);
                chk("rnd_stall", {31'b0, stall}, {31'b0, !r_ack});
                chk("rnd_addr", dmem_addr, rx.alu_result);
                chk("rnd_wdata", dmem_wdata, rx.write_data);
                chk("rnd_we", {31'b0, dmem_we}, {31'b0, rx.mem_write});
            end else begin
                chk("rnd_req", {31'b0, dmem_req}, 32'h0);
                chk("rnd_stall", {31'b0, stall}, 32'h0);
            end

            e_timeout  = 1'b0;
            e_misalign = 1'b0;
            if (m_busy) begin
                if (r_ack) begin
                    model_retire(m_tx, r_rdata);
                    m_busy = 1'b0;
                end else begin
                    m_waited++;
                    e_wb_we = 1'b0;
                    if (m_waited == TbMaxWait) begin
                        e_timeout = 1'b1;
                        m_busy    = 1'b0;
                    end
                end
            end else if (rx.mem_read || rx.mem_write) begin
                if (tb_misaligned(rx.alu_result)) begin
                    e_misalign = 1'b1;
                    e_wb_we    = 1'b0;
                end else if (r_ack) begin
                    model_retire(rx, r_rdata);
                end else begin
                    m_busy   = 1'b1;
                    m_tx     = rx;
                    m_waited = 0;
                    e_wb_we  = 1'b0;
                end
            end else begin
                model_retire(rx, r_rdata);
            end

            cycle();
            chk("rnd_wb_data", wb_data, e_wb_data);
            chk("rnd_wb_rd", {27'b0, wb_rd}, {27'b0, e_wb_rd});
            chk("rnd_wb_we", {31'b0, wb_reg_write}, {31'b0, e_wb_we});
            chk("rnd_bp_wb", bp_wb, e_wb_data);
            chk("rnd_timeout", {31'b0, timeout}, {31'b0, e_timeout});
            chk("rnd_misalign", {31'b0, misalign}, {31'b0, e_misalign});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
